// File: rtl/hash_ctrl_pkg.sv
// rtl/hash_ctrl_pkg.sv - shared types and constants for the hash sequencing controller
package hash_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } hash_ctrl_state_e;

    // Control register bit positions (write side)
    localparam int CtrlStartBit = 0;
    localparam int CtrlInitBit  = 1;
    localparam int CtrlClearBit = 2;

    // Status register bit positions (read side)
    localparam int StatBusyBit  = 0;
    localparam int StatDoneBit  = 1;
    localparam int StatErrorBit = 2;

    // Default block and digest widths
    localparam int DefaultBlockWidth  = 512;
    localparam int DefaultDigestWidth = 160;

endpackage

// File: rtl/hash_ctrl_watchdog.sv
// rtl/hash_ctrl_watchdog.sv - loadable up-counter raising an expiry pulse on its last cycle
module hash_ctrl_watchdog #(
    parameter int TimeoutCycles = 1024,
    parameter int CntWidth      = $clog2(TimeoutCycles + 1)
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    input  logic i_en,
    output logic o_expired
);

    localparam logic [CntWidth-1:0] LastCount = CntWidth'(TimeoutCycles - 1);

    logic [CntWidth-1:0] r_count;

    // Restart from zero on load; otherwise count enabled cycles, holding at the last value
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= '0;
        end else if (i_en && (r_count != LastCount)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = i_en && (r_count == LastCount);

endmodule

// File: rtl/hash_ctrl.sv
// rtl/hash_ctrl.sv - snapshots a block, hands it to the hash core and collects the digest
module hash_ctrl
    import hash_ctrl_pkg::*;
#(
    parameter int BlockWidth    = DefaultBlockWidth,
    parameter int DigestWidth   = DefaultDigestWidth,
    parameter int TimeoutCycles = 1024,
    parameter int CntWidth      = $clog2(TimeoutCycles + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   ctrl_start_i,
    input  logic                   ctrl_init_i,
    input  logic                   ctrl_clear_i,
    input  logic [BlockWidth-1:0]  block_i,
    output logic                   core_valid_o,
    input  logic                   core_ready_i,
    output logic [BlockWidth-1:0]  core_block_o,
    output logic                   core_init_o,
    input  logic                   core_done_i,
    input  logic [DigestWidth-1:0] core_digest_i,
    output logic                   core_abort_o,
    output logic [DigestWidth-1:0] digest_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   error_o,
    output logic                   irq_o
);

    hash_ctrl_state_e r_state;
    hash_ctrl_state_e w_state_next;

    logic [BlockWidth-1:0]  r_block;
    logic                   r_init;
    logic [DigestWidth-1:0] r_digest;
    logic                   r_done;
    logic                   r_error;
    logic                   r_irq;

    logic w_busy;
    logic w_start_idle;
    logic w_start_busy;
    logic w_handshake;
    logic w_done_evt;
    logic w_expired;
    logic w_timeout_evt;
    logic w_set_error;

    assign w_busy        = (r_state != IDLE);
    assign w_start_idle  = (r_state == IDLE) && ctrl_start_i;
    assign w_start_busy  = w_busy && ctrl_start_i;
    assign w_handshake   = (r_state == REQ) && core_ready_i;
    assign w_done_evt    = (r_state == WAIT) && core_done_i;
    // A completion in the expiry cycle takes priority over the timeout
    assign w_timeout_evt = w_expired && !core_done_i;
    assign w_set_error   = w_timeout_evt || w_start_busy;

    hash_ctrl_watchdog #(
        .TimeoutCycles (TimeoutCycles),
        .CntWidth      (CntWidth)
    ) u_watchdog (
        .i_clk     (clk_i),
        .i_rst_n   (rst_ni),
        .i_load    (w_handshake),
        .i_en      (r_state == WAIT),
        .o_expired (w_expired)
    );

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; a start while busy never disturbs sequencing
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (ctrl_start_i) w_state_next = REQ;
            REQ:     if (core_ready_i) w_state_next = WAIT;
            WAIT:    if (core_done_i || w_expired) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Block and init snapshot taken on an accepted start, stable while the request is pending
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_block <= '0;
            r_init  <= 1'b0;
        end else if (w_start_idle) begin
            r_block <= block_i;
            r_init  <= ctrl_init_i;
        end
    end

    // Digest capture only on a completion while waiting; survives clear and error
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_digest <= '0;
        end else if (w_done_evt) begin
            r_digest <= core_digest_i;
        end
    end

    // Sticky flags: set beats clear, and an accepted start clears both
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_irq   <= 1'b0;
        end else begin
            if (w_done_evt) begin
                r_done <= 1'b1;
            end else if (ctrl_clear_i || w_start_idle) begin
                r_done <= 1'b0;
            end
            if (w_set_error) begin
                r_error <= 1'b1;
            end else if (ctrl_clear_i || w_start_idle) begin
                r_error <= 1'b0;
            end
            r_irq <= w_done_evt || w_set_error;
        end
    end

    assign core_valid_o = (r_state == REQ);
    assign core_block_o = r_block;
    assign core_init_o  = r_init;
    assign core_abort_o = w_timeout_evt;
    assign digest_o     = r_digest;
    assign busy_o       = w_busy;
    assign done_o       = r_done;
    assign error_o      = r_error;
    assign irq_o        = r_irq;

endmodule

// File: tb/tb_hash_ctrl.sv
// tb/tb_hash_ctrl.sv - directed and randomized self-checking bench for hash_ctrl
module tb_hash_ctrl;

    localparam int BW = 512;
    localparam int DW = 160;
    localparam int TO = 16;

    logic          clk;
    logic          rst_n;
    logic          ctrl_start_i;
    logic          ctrl_init_i;
    logic          ctrl_clear_i;
    logic [BW-1:0] block_i;
    logic          core_valid_o;
    logic          core_ready_i;
    logic [BW-1:0] core_block_o;
    logic          core_init_o;
    logic          core_done_i;
    logic [DW-1:0] core_digest_i;
    logic          core_abort_o;
    logic [DW-1:0] digest_o;
    logic          busy_o;
    logic          done_o;
    logic          error_o;
    logic          irq_o;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference state: what software should observe after each scenario step
    logic [BW-1:0] m_block;
    logic          m_init;
    logic [DW-1:0] m_digest;
    logic          m_done;
    logic          m_error;

    hash_ctrl #(
        .BlockWidth    (BW),
        .DigestWidth   (DW),
        .TimeoutCycles (TO)
    ) u_dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .ctrl_start_i  (ctrl_start_i),
        .ctrl_init_i   (ctrl_init_i),
        .ctrl_clear_i  (ctrl_clear_i),
        .block_i       (block_i),
        .core_valid_o  (core_valid_o),
        .core_ready_i  (core_ready_i),
        .core_block_o  (core_block_o),
        .core_init_o   (core_init_o),
        .core_done_i   (core_done_i),
        .core_digest_i (core_digest_i),
        .core_abort_o  (core_abort_o),
        .digest_o      (digest_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .error_o       (error_o),
        .irq_o         (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BW-1:0] rnd_block();
        logic [BW-1:0] r;
        for (int i = 0; i < BW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [DW-1:0] rnd_digest();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, BW'(core_valid_o), '0);
        chk({tag, "_busy"},  BW'(busy_o), '0);
        chk({tag, "_done"},  BW'(done_o), '0);
        chk({tag, "_error"}, BW'(error_o), '0);
        chk({tag, "_irq"},   BW'(irq_o), '0);
        chk({tag, "_abort"}, BW'(core_abort_o), '0);
        chk({tag, "_init"},  BW'(core_init_o), '0);
        chk({tag, "_block"}, core_block_o, '0);
        chk({tag, "_digest"}, BW'(digest_o), '0);
    endtask

    // Issue an accepted start from IDLE and check the request appears next cycle
    task automatic start_op(input logic [BW-1:0] blk, input logic ini, input logic clr);
        block_i      = blk;
        ctrl_init_i  = ini;
        ctrl_clear_i = clr;
        ctrl_start_i = 1'b1;
        cyc();
        ctrl_start_i = 1'b0;
        ctrl_clear_i = 1'b0;
        m_block = blk;
        m_init  = ini;
        m_done  = 1'b0;
        m_error = 1'b0;
        chk("valid_latency", BW'(core_valid_o), BW'(1));
        chk("busy_in_req", BW'(busy_o), BW'(1));
        chk("done_cleared_on_start", BW'(done_o), BW'(m_done));
        chk("error_cleared_on_start", BW'(error_o), BW'(m_error));
    endtask

    // Hold ready low for bp cycles while scrambling block_i; snapshot must not move
    task automatic handshake(input int bp);
        int nv;
        nv = 0;
        for (int i = 0; i <= bp; i++) begin
            core_ready_i = (i == bp);
            block_i      = rnd_block();
            if (core_valid_o) nv++;
            chk("snapshot_block", core_block_o, m_block);
            chk("snapshot_init", BW'(core_init_o), BW'(m_init));
            cyc();
        end
        core_ready_i = 1'b0;
        chk("valid_cycles", BW'(nv), BW'(bp + 1));
        chk("valid_drop", BW'(core_valid_o), '0);
    endtask

    // Wait w cycles in WAIT, then deliver the digest (optionally with a clear in the same cycle)
    task automatic finish_op(input int w, input logic [DW-1:0] dig, input logic clr);
        repeat (w) cyc();
        core_done_i   = 1'b1;
        core_digest_i = dig;
        ctrl_clear_i  = clr;
        #1;
        chk("no_abort_on_done", BW'(core_abort_o), '0);
        cyc();
        core_done_i   = 1'b0;
        ctrl_clear_i  = 1'b0;
        core_digest_i = rnd_digest();
        m_done   = 1'b1;
        m_digest = dig;
        chk("done_set", BW'(done_o), BW'(m_done));
        chk("error_after_done", BW'(error_o), BW'(m_error));
        chk("irq_on_done", BW'(irq_o), BW'(1));
        chk("digest_captured", BW'(digest_o), BW'(m_digest));
        chk("idle_after_done", BW'(busy_o), '0);
        cyc();
        chk("irq_single_pulse", BW'(irq_o), '0);
    endtask

    initial begin
        int hit;
        logic [BW-1:0] a5;
        logic [DW-1:0] basic_dig;

        a5        = {64{8'hA5}};
        basic_dig = 160'h67452301EFCDAB8998BADCFE10325476C3D2E1F0;

        ctrl_start_i  = 1'b0;
        ctrl_init_i   = 1'b0;
        ctrl_clear_i  = 1'b0;
        block_i       = '0;
        core_ready_i  = 1'b0;
        core_done_i   = 1'b0;
        core_digest_i = '0;
        m_block = '0; m_init = 1'b0; m_digest = '0; m_done = 1'b0; m_error = 1'b0;

        // Reset state
        rst_n = 1'b0;
        #1;
        chk_all_zero("reset");
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();

        // Basic run
        start_op(a5, 1'b1, 1'b0);
        handshake(0);
        finish_op(12, basic_dig, 1'b0);

        // Backpressure: ready low for 5 cycles while block_i goes to zero
        start_op(rnd_block(), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            block_i = '0;
            chk("bp_valid_held", BW'(core_valid_o), BW'(1));
            chk("bp_snapshot", core_block_o, m_block);
            cyc();
        end
        core_ready_i = 1'b1;
        chk("bp_valid_sixth", BW'(core_valid_o), BW'(1));
        cyc();
        core_ready_i = 1'b0;
        chk("bp_valid_drop", BW'(core_valid_o), '0);
        finish_op(3, rnd_digest(), 1'b0);

        // Done in the expiry cycle: completion wins
        start_op(rnd_block(), 1'b1, 1'b0);
        handshake(1);
        finish_op(TO - 1, rnd_digest(), 1'b0);

        // Timeout with no completion
        start_op(rnd_block(), 1'b0, 1'b0);
        handshake(0);
        hit = 0;
        for (int i = 1; i <= 4 * TO && hit == 0; i++) begin
            #1;
            if (core_abort_o === 1'b1) hit = i;
            else cyc();
        end
        chk("timeout_cycle", BW'(hit), BW'(TO));
        cyc();
        m_error = 1'b1;
        chk("abort_single_pulse", BW'(core_abort_o), '0);
        chk("timeout_error", BW'(error_o), BW'(m_error));
        chk("timeout_irq", BW'(irq_o), BW'(1));
        chk("timeout_done", BW'(done_o), BW'(m_done));
        chk("timeout_idle", BW'(busy_o), '0);
        chk("timeout_digest_kept", BW'(digest_o), BW'(m_digest));

        // Completion and ready outside their states are ignored
        core_done_i   = 1'b1;
        core_digest_i = rnd_digest();
        core_ready_i  = 1'b1;
        cyc();
        core_done_i  = 1'b0;
        core_ready_i = 1'b0;
        chk("idle_done_digest", BW'(digest_o), BW'(m_digest));
        chk("idle_done_flag", BW'(done_o), BW'(m_done));
        chk("idle_done_irq", BW'(irq_o), '0);
        chk("idle_ready_busy", BW'(busy_o), '0);

        // Clear together with start in IDLE after an error
        start_op(rnd_block(), 1'b1, 1'b1);
        handshake(2);
        cyc();
        cyc();
        cyc();

        // Start while busy in WAIT
        ctrl_start_i = 1'b1;
        block_i      = rnd_block();
        cyc();
        ctrl_start_i = 1'b0;
        m_error = 1'b1;
        chk("busy_start_error", BW'(error_o), BW'(m_error));
        chk("busy_start_irq", BW'(irq_o), BW'(1));
        chk("busy_start_busy", BW'(busy_o), BW'(1));
        chk("busy_start_snapshot", core_block_o, m_block);
        cyc();
        chk("busy_start_irq_pulse", BW'(irq_o), '0);
        finish_op(4, rnd_digest(), 1'b0);

        // Clear while busy clears flags only; clear with done keeps done
        start_op(rnd_block(), 1'b0, 1'b0);
        handshake(0);
        ctrl_start_i = 1'b1;
        cyc();
        ctrl_start_i = 1'b0;
        m_error = 1'b1;
        chk("busy_start2_error", BW'(error_o), BW'(m_error));
        ctrl_clear_i = 1'b1;
        cyc();
        ctrl_clear_i = 1'b0;
        m_error = 1'b0;
        chk("busy_clear_error", BW'(error_o), BW'(m_error));
        chk("busy_clear_state", BW'(busy_o), BW'(1));
        finish_op(2, rnd_digest(), 1'b1);

        // Randomized operations
        for (int n = 0; n < 8; n++) begin
            start_op(rnd_block(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            handshake(int'($urandom_range(0, 6)));
            finish_op(int'($urandom_range(0, TO - 1)), rnd_digest(), 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of WAIT
        start_op(rnd_block(), 1'b1, 1'b0);
        handshake(0);
        cyc();
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        m_block = '0; m_init = 1'b0; m_digest = '0; m_done = 1'b0; m_error = 1'b0;
        chk_all_zero("async_reset");
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        cyc();
        chk("post_reset_idle", BW'(busy_o), '0);

        // Basic run again after reset
        start_op(a5, 1'b1, 1'b0);
        handshake(0);
        finish_op(12, basic_dig, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
